// File: rtl/wheels_cmd_sequencer.sv
// wheels_cmd_sequencer: turns synchronized line/obstacle sensors and SoC
// maneuver requests into the 3-bit motion command for the wheel driver.
module wheels_cmd_sequencer #(
  parameter int unsigned TURN_CYCLES = 100_000_000,
  parameter int unsigned REV_CYCLES  = 50_000_000,
  parameter int unsigned LOST_CYCLES = 20_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sensor,
  input  logic       obstacle,
  input  logic       req_valid,
  input  logic [1:0] req_code,
  output logic       req_ready,
  output logic [2:0] state,
  output logic       busy,
  output logic       done,
  output logic       lost
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FOLLOW  = 3'd1,
    S_BLOCKED = 3'd2,
    S_TURN    = 3'd3,
    S_REVERSE = 3'd4
  } fsm_t;

  localparam logic [2:0] CMD_STRAIGHT = 3'b000;
  localparam logic [2:0] CMD_RIGHT    = 3'b001;
  localparam logic [2:0] CMD_LEFT     = 3'b010;
  localparam logic [2:0] CMD_STOP     = 3'b011;
  localparam logic [2:0] CMD_TURN     = 3'b100;
  localparam logic [2:0] CMD_REVERSE  = 3'b101;

  // Last counter value of a maneuver: the command is held for counts 0..N-1.
  localparam logic [31:0] TURN_LAST = 32'(TURN_CYCLES - 1);
  localparam logic [31:0] REV_LAST  = 32'(REV_CYCLES - 1);
  localparam logic [31:0] LOST_LIM  = 32'(LOST_CYCLES);
  localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

  logic [2:0]  sensor_s1_q, sensor_s2_q;
  logic        obstacle_s1_q, obstacle_s2_q;
  fsm_t        fsm_q, fsm_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [31:0] counter_q, counter_d;
  logic        lost_q, lost_d;
  logic        done_q, done_d;
  logic        accept;
  logic [2:0]  line_cmd;

  // Two-flop synchronizers for the asynchronous sensor inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sensor_s1_q   <= 3'b000;
      sensor_s2_q   <= 3'b000;
      obstacle_s1_q <= 1'b0;
      obstacle_s2_q <= 1'b0;
    end else begin
      sensor_s1_q   <= sensor;
      sensor_s2_q   <= sensor_s1_q;
      obstacle_s1_q <= obstacle;
      obstacle_s2_q <= obstacle_s1_q;
    end
  end

  // Line-sensor to steering decode; 000 is handled separately (hold).
  always_comb begin
    line_cmd = CMD_STRAIGHT;
    case (sensor_s2_q)
      3'b001, 3'b011: line_cmd = CMD_RIGHT;
      3'b100, 3'b110: line_cmd = CMD_LEFT;
      default:        line_cmd = CMD_STRAIGHT;
    endcase
  end

  // Requests are only taken in the non-timed states (no maneuver abort).
  assign req_ready = (fsm_q == S_IDLE) || (fsm_q == S_FOLLOW) || (fsm_q == S_BLOCKED);
  assign accept    = req_valid && req_ready;

  // Next-state, command, counter and flag logic; request beats obstacle beats sensors.
  always_comb begin
    fsm_d     = fsm_q;
    cmd_d     = cmd_q;
    counter_d = counter_q;
    lost_d    = lost_q;
    done_d    = 1'b0;
    if (accept) begin
      counter_d = 32'd0;
      lost_d    = 1'b0;
      case (req_code)
        2'd0: fsm_d = S_FOLLOW;
        2'd1: begin fsm_d = S_IDLE;    cmd_d = CMD_STOP;    end
        2'd2: begin fsm_d = S_TURN;    cmd_d = CMD_TURN;    end
        default: begin fsm_d = S_REVERSE; cmd_d = CMD_REVERSE; end
      endcase
    end else begin
      case (fsm_q)
        S_IDLE: cmd_d = CMD_STOP;
        S_FOLLOW: begin
          if (obstacle_s2_q) begin
            fsm_d = S_BLOCKED;
            cmd_d = CMD_STOP;
          end else if (sensor_s2_q == 3'b000) begin
            // Line not seen: keep steering as before until the lost budget runs out.
            if (counter_q >= LOST_LIM) begin
              fsm_d  = S_IDLE;
              cmd_d  = CMD_STOP;
              lost_d = 1'b1;
            end else if (counter_q != CNT_MAX) begin
              counter_d = counter_q + 32'd1;
            end
          end else begin
            counter_d = 32'd0;
            cmd_d     = line_cmd;
          end
        end
        S_BLOCKED: begin
          cmd_d = CMD_STOP;
          if (!obstacle_s2_q) fsm_d = S_FOLLOW;
        end
        S_TURN: begin
          if (counter_q >= TURN_LAST) begin
            fsm_d     = S_IDLE;
            cmd_d     = CMD_STOP;
            done_d    = 1'b1;
            counter_d = 32'd0;
          end else begin
            counter_d = counter_q + 32'd1;
          end
        end
        S_REVERSE: begin
          if (counter_q >= REV_LAST) begin
            fsm_d     = S_IDLE;
            cmd_d     = CMD_STOP;
            done_d    = 1'b1;
            counter_d = 32'd0;
          end else begin
            counter_d = counter_q + 32'd1;
          end
        end
        default: begin
          fsm_d = S_IDLE;
          cmd_d = CMD_STOP;
        end
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= S_IDLE;
      cmd_q     <= CMD_STOP;
      counter_q <= 32'd0;
      lost_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      cmd_q     <= cmd_d;
      counter_q <= counter_d;
      lost_q    <= lost_d;
      done_q    <= done_d;
    end
  end

  assign state = cmd_q;
  assign busy  = (fsm_q == S_TURN) || (fsm_q == S_REVERSE);
  assign done  = done_q;
  assign lost  = lost_q;

endmodule
